cnt_event_cond: RTL

Event conditioner that sits directly upstream of the 3-bit modulo-7 up-counter and drives its UP_ENABLE, UP_ENABLE2 and CLEAR inputs. It synchronizes and debounces three raw level inputs, converts each debounced rising edge into a single-cycle pulse, and arbitrates them so that at most one output is high per cycle. Without this arbitration, two coincident increment requests would be counted once by the downstream counter, which services only one enable per cycle; this block ensures no increment is lost.

---
 rtl/cnt_event_cond.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cnt_event_cond.sv
// -----------------------------------------------------------------------------
// cnt_event_cond
//
// Event conditioner for the modulo-7 up-counter. Three raw, asynchronous,
// possibly bouncing level inputs are each synchronized, debounced and turned
// into a one-cycle event on the rising edge of the filtered level. A
// registered priority arbiter then drives at most one of the counter's
// CLEAR / UP_ENABLE / UP_ENABLE2 inputs per cycle. A channel-B event that
// collides with a channel-A event is deferred by one cycle, so no increment
// is lost.
//
// Parameters
//   DB_CYCLES   consecutive differing synchronized samples needed before the
//               filtered level follows (legal 2..15)
//
// Ports
//   CLK         clock, rising edge
//   RSTN        asynchronous active-low reset
//   EV_A_IN     raw increment request A
//   EV_B_IN     raw increment request B
//   CLR_IN      raw clear request
//   UP_ENABLE   one-cycle increment pulse, channel A
//   UP_ENABLE2  one-cycle increment pulse, channel B
//   CLEAR       one-cycle clear pulse
//   B_PEND      high while a channel-B pulse is deferred
//
// Output handshake: the outputs are pulses with no back-pressure. A pulse is
// valid for exactly the one cycle it is high; the downstream counter is
// always ready and must consume it in that cycle.
// -----------------------------------------------------------------------------
module cnt_event_cond #(
  parameter int DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic EV_A_IN,
  input  logic EV_B_IN,
  input  logic CLR_IN,
  output logic UP_ENABLE,
  output logic UP_ENABLE2,
  output logic CLEAR,
  output logic B_PEND
);

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  // Channel index: 0 = A, 1 = B, 2 = clear
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_filt;
  logic [2:0] r_filt_d;
  logic [3:0] r_cnt [3];
  logic [2:0] w_ev;

  assign w_raw = {CLR_IN, EV_B_IN, EV_A_IN};

  // Two-flop synchronizer plus a delayed copy of filt for edge detection
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_filt_d <= '0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
    end
  end

  // Debounce: filt follows sync2 only after DB_CYCLES consecutive samples
  // that differ from it; any agreeing sample restarts the count.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_filt <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Rising edge of filt only; falling edges are ignored
  assign w_ev = r_filt & ~r_filt_d;

  // Arbiter next-state: clear beats everything (and drops a pending B),
  // A beats B (B is deferred), a pending B beats a fresh B (and absorbs it).
  logic w_up_nxt;
  logic w_up2_nxt;
  logic w_clr_nxt;
  logic w_pend_nxt;

  always_comb begin
    w_up_nxt   = 1'b0;
    w_up2_nxt  = 1'b0;
    w_clr_nxt  = 1'b0;
    w_pend_nxt = 1'b0;
    if (w_ev[2]) begin
      w_clr_nxt = 1'b1;
    end else if (w_ev[0]) begin
      w_up_nxt   = 1'b1;
      w_pend_nxt = B_PEND | w_ev[1];
    end else if (B_PEND) begin
      w_up2_nxt = 1'b1;
    end else if (w_ev[1]) begin
      w_up2_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      UP_ENABLE  <= 1'b0;
      UP_ENABLE2 <= 1'b0;
      CLEAR      <= 1'b0;
      B_PEND     <= 1'b0;
    end else begin
      UP_ENABLE  <= w_up_nxt;
      UP_ENABLE2 <= w_up2_nxt;
      CLEAR      <= w_clr_nxt;
      B_PEND     <= w_pend_nxt;
    end
  end

endmodule
